// File: rtl/load_wb_unit.sv
// load_wb_unit: single-outstanding load sequencer sharing one register-file
// write port with the ALU. A load walks IDLE -> REQ -> WAIT -> WB. Its result
// sits in a load buffer until the write port is free, because ALU writes always
// take the port first.
// Optional feature macro: LOAD_TIMEOUT_EN. When it is defined, a load whose
// response does not arrive within TIMEOUT_CYCLES WAIT cycles is aborted and
// ld_err pulses for one cycle. When it is undefined, WAIT lasts indefinitely
// and ld_err is tied low.
module load_wb_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wr_en,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_addr,
    output logic        mem_req_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  write_reg,
    output logic [31:0] w_data,
    output logic        reg_write,
    output logic        ld_busy,
    output logic [4:0]  ld_pending_rd,
    output logic        ld_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] w_data_q, w_data_d;
    logic        timeout_hit;

    // Split the response word into byte lanes for the byte loads.
    logic [7:0]  rdata_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed lane and sign- or zero-extend it according to funct3.
    always_comb begin
        byte_sel = rdata_lane[addr_q[1:0]];
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'h000000, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'h0000, half_sel};
            default: ext_data = mem_rdata;   // LW and the unused encodings
        endcase
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_err_q, ld_err_d;

    // The last silent WAIT cycle before the limit aborts the load.
    assign timeout_hit = (state_q == WAIT) && !mem_rsp_valid && (cnt_q == CNT_LAST);

    // Count silent WAIT cycles; restart the count as the request is accepted.
    always_comb begin
        cnt_d    = cnt_q;
        ld_err_d = timeout_hit;
        if (state_q == REQ && mem_req_ready) begin
            cnt_d = '0;
        end else if (state_q == WAIT && !mem_rsp_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign ld_err = ld_err_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign ld_err         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Load sequencing plus write-port arbitration, in which the ALU always wins.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        reg_write_d = 1'b0;
        write_reg_d = write_reg_q;
        w_data_d    = w_data_q;

        case (state_q)
            IDLE: begin
                if (ld_req_valid) begin
                    rd_d     = ld_rd;
                    funct3_d = ld_funct3;
                    addr_d   = ld_addr;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    buf_d   = ext_data;
                    state_d = WB;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (!alu_wr_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A destination of x0 still occupies the port, but it never writes.
        if (alu_wr_en) begin
            reg_write_d = (alu_rd != 5'd0);
            write_reg_d = alu_rd;
            w_data_d    = alu_data;
        end else if (state_q == WB) begin
            reg_write_d = (rd_q != 5'd0);
            write_reg_d = rd_q;
            w_data_d    = buf_q;
        end
    end

    // State, captured load fields, load buffer and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_q        <= 5'd0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            buf_q       <= 32'd0;
            reg_write_q <= 1'b0;
            write_reg_q <= 5'd0;
            w_data_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            reg_write_q <= reg_write_d;
            write_reg_q <= write_reg_d;
            w_data_q    <= w_data_d;
        end
    end

    assign ld_req_ready  = (state_q == IDLE);
    assign ld_busy       = (state_q != IDLE);
    assign ld_pending_rd = ld_busy ? rd_q : 5'd0;
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign write_reg     = write_reg_q;
    assign w_data        = w_data_q;
    assign reg_write     = reg_write_q;

endmodule
